mac_seq: RTL and testbench

//  Initiator/controller for the mac accumulator: for each output neuron, streams NUM_IN input/weight pairs

---
 rtl/snn_pkg.sv | 39 +++
 rtl/acc_sat.sv | 22 ++
 rtl/mac_seq.sv | 186 ++++++++++++++++++
 tb/tb_mac_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// ============================================================================
// Module  : snn_pkg
// Brief   : Shared widths, sequencer state encoding and accumulator saturation.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package snn_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    ACCUM  = 3'd2,
    SAMPLE = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Flags win over the value; otherwise keep acc[11:4] when it fits in 8 bits.
  function automatic logic [DATA_W-1:0] sat_acc(input logic [ACC_W-1:0] acc,
                                                input logic              of,
                                                input logic              uf);
    if (of)
      return 8'h7F;
    else if (uf)
      return 8'h80;
    else if (acc[15:11] == {5{acc[15]}})
      return acc[11:4];
    else
      return acc[15] ? 8'h80 : 8'h7F;
  endfunction

endpackage

`default_nettype wire

// File: rtl/acc_sat.sv
// ============================================================================
// Module  : acc_sat
// Brief   : Combinational 16->8 accumulator saturation with flag override.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module acc_sat
  import snn_pkg::*;
(
  input  logic [ACC_W-1:0]  acc,
  input  logic              of,
  input  logic              uf,
  output logic [DATA_W-1:0] res
);

  assign res = sat_acc(acc, of, uf);

endmodule

`default_nettype wire

// File: rtl/mac_seq.sv
// ============================================================================
// Module  : mac_seq
// Brief   : Streams input/weight pairs into mac per neuron, saturates, writes out.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mac_seq
  import snn_pkg::*;
#(
  parameter int NUM_IN  = 784,
  parameter int NUM_OUT = 32,
  parameter int AW_IN   = $clog2(NUM_IN),
  parameter int AW_W    = $clog2(NUM_IN*NUM_OUT),
  parameter int AW_OUT  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [AW_IN-1:0]  in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic [AW_W-1:0]   w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic              mac_clr_n,
  input  logic [ACC_W-1:0]  mac_acc,
  input  logic              mac_of,
  input  logic              mac_uf,
  output logic [AW_OUT-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_we
);

  localparam logic [AW_IN-1:0]  c_K_LAST = AW_IN'(NUM_IN - 1);
  localparam logic [AW_IN-1:0]  c_K_PRE  = AW_IN'(NUM_IN - 2);
  localparam logic [AW_OUT-1:0] c_N_LAST = AW_OUT'(NUM_OUT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AW_IN-1:0]    r_k;
  logic [AW_OUT-1:0]   r_neuron;
  logic [AW_IN-1:0]    r_in_addr;
  logic [AW_W-1:0]     r_w_addr;
  logic                r_of_s;
  logic                r_uf_s;
  logic                r_of_first;
  logic [DATA_W-1:0]   r_result;
  logic                w_fold;
  logic                w_of_all;
  logic                w_uf_all;
  logic                w_of_first;
  logic                w_sat_of;
  logic                w_sat_uf;
  logic [DATA_W-1:0]   w_sat_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    out_we      = 1'b0;
    mac_clr_n   = 1'b0;
    mac_a       = '0;
    mac_b       = '0;
    w_fold      = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = CLR;
      end
      CLR: w_state_nxt = ACCUM;
      ACCUM: begin
        mac_clr_n = 1'b1;
        mac_a     = in_data;
        mac_b     = w_data;
        // mac_of is one add behind, so the first ACCUM cycle has nothing to fold.
        w_fold    = (r_k != '0);
        if (r_k == c_K_LAST) w_state_nxt = SAMPLE;
      end
      SAMPLE: begin
        mac_clr_n   = 1'b1;
        w_fold      = 1'b1;
        w_state_nxt = WRITE;
      end
      WRITE: begin
        out_we      = 1'b1;
        w_state_nxt = (r_neuron == c_N_LAST) ? DONE : CLR;
      end
      DONE: begin
        busy        = 1'b0;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Sticky flags; whichever flag appears first decides the saturation direction.
  assign w_of_all   = r_of_s | (w_fold & mac_of);
  assign w_uf_all   = r_uf_s | (w_fold & mac_uf);
  assign w_of_first = r_of_first | (w_fold & mac_of & ~r_of_s & ~r_uf_s);
  assign w_sat_of   = w_of_all & (~w_uf_all | w_of_first);
  assign w_sat_uf   = w_uf_all & ~w_sat_of;

  acc_sat u_acc_sat (
    .acc (mac_acc),
    .of  (w_sat_of),
    .uf  (w_sat_uf),
    .res (w_sat_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k        <= '0;
      r_neuron   <= '0;
      r_in_addr  <= '0;
      r_w_addr   <= '0;
      r_of_s     <= 1'b0;
      r_uf_s     <= 1'b0;
      r_of_first <= 1'b0;
      r_result   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_neuron  <= '0;
            r_in_addr <= '0;
            r_w_addr  <= '0;
          end
        end
        CLR: begin
          r_k        <= '0;
          r_in_addr  <= r_in_addr + 1'b1;
          r_w_addr   <= r_w_addr + 1'b1;
          r_of_s     <= 1'b0;
          r_uf_s     <= 1'b0;
          r_of_first <= 1'b0;
        end
        ACCUM: begin
          r_k        <= r_k + 1'b1;
          r_of_s     <= w_of_all;
          r_uf_s     <= w_uf_all;
          r_of_first <= w_of_first;
          // Addresses run one pair ahead of the data path.
          if (r_k < c_K_PRE) begin
            r_in_addr <= r_in_addr + 1'b1;
            r_w_addr  <= r_w_addr + 1'b1;
          end
        end
        SAMPLE: begin
          r_of_s     <= w_of_all;
          r_uf_s     <= w_uf_all;
          r_of_first <= w_of_first;
          r_result   <= w_sat_res;
        end
        WRITE: begin
          if (r_neuron != c_N_LAST) begin
            r_neuron  <= r_neuron + 1'b1;
            r_in_addr <= '0;
            r_w_addr  <= r_w_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_addr  = r_in_addr;
  assign w_addr   = r_w_addr;
  assign out_addr = r_neuron;
  assign out_data = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mac_seq.sv
// ============================================================================
// Module  : tb_mac_seq
// Brief   : Self-checking bench for mac_seq with memory and mac models.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mac_seq;

  localparam int NI  = 4;
  localparam int NO  = 2;
  localparam int AWI = 2;
  localparam int AWW = 3;
  localparam int AWO = 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           busy, done, mac_clr_n, out_we, mac_of, mac_uf;
  logic [AWI-1:0] in_addr;
  logic [AWW-1:0] w_addr;
  logic [AWO-1:0] out_addr;
  logic [7:0]     in_data, w_data, mac_a, mac_b, out_data;
  logic [15:0]    mac_acc;

  logic [7:0] in_mem [NI];
  logic [7:0] w_mem  [NI*NO];

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  mac_seq #(.NUM_IN(NI), .NUM_OUT(NO), .AW_IN(AWI), .AW_W(AWW), .AW_OUT(AWO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_addr(in_addr), .in_data(in_data), .w_addr(w_addr), .w_data(w_data),
    .mac_a(mac_a), .mac_b(mac_b), .mac_clr_n(mac_clr_n), .mac_acc(mac_acc),
    .mac_of(mac_of), .mac_uf(mac_uf), .out_addr(out_addr), .out_data(out_data),
    .out_we(out_we)
  );

  // Synchronous memories with one-cycle read latency.
  always @(posedge clk) begin
    in_data <= in_mem[in_addr];
    w_data  <= w_mem[w_addr];
  end

  // mac: wrapping 16-bit accumulator, flags describe the most recent add.
  int m_sum;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_acc <= '0; mac_of <= 1'b0; mac_uf <= 1'b0;
    end else if (!mac_clr_n) begin
      mac_acc <= '0; mac_of <= 1'b0; mac_uf <= 1'b0;
    end else begin
      m_sum = $signed(mac_acc) + $signed(mac_a) * $signed(mac_b);
      mac_acc <= m_sum[15:0];
      mac_of  <= (m_sum > 32767);
      mac_uf  <= (m_sum < -32768);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected neuron output from the arithmetic rules of the datapath.
  function automatic logic [7:0] expect_out(input int n);
    int  acc = 0;
    int  p;
    bit  of = 0, uf = 0, of_first = 0;
    logic signed [15:0] t;
    for (int k = 0; k < NI; k++) begin
      p = $signed(in_mem[k]) * $signed(w_mem[n*NI + k]);
      acc = acc + p;
      if (acc > 32767) begin
        if (!of && !uf) of_first = 1;
        of = 1;
      end else if (acc < -32768) begin
        uf = 1;
      end
      t = acc[15:0];
      acc = t;
    end
    if (of && (!uf || of_first)) return 8'h7F;
    if (uf) return 8'h80;
    if (acc >= -2048 && acc <= 2047) begin
      t = acc[15:0];
      return t[11:4];
    end
    return (acc < 0) ? 8'h80 : 8'h7F;
  endfunction

  task automatic fill(input logic [7:0] iv, input logic [7:0] wv);
    for (int i = 0; i < NI; i++) in_mem[i] = iv;
    for (int i = 0; i < NI*NO; i++) w_mem[i] = wv;
  endtask

  task automatic run_pass(input bit pulse_mid);
    int cyc = 0;
    int nw = 0;
    bit got_done = 0;
    @(negedge clk) start = 1'b1;
    while (!got_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        check("busy_run", busy, 1);
      end
      if (pulse_mid && cyc == 4) start = 1'b1;
      if (pulse_mid && cyc == 5) start = 1'b0;
      if (out_we) begin
        if (nw < NO) begin
          check("wr_addr", out_addr, nw);
          check("wr_data", out_data, expect_out(nw));
        end
        nw++;
      end
      if (done) begin
        got_done = 1;
        check("done_cyc", cyc, NO*(NI+3)+1);
        check("done_busy", busy, 0);
      end
    end
    check("done_seen", got_done, 1);
    check("we_count", nw, NO);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("done_pulse", done, 0);
  endtask

  initial begin
    fill(8'h00, 8'h00);
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", out_we, 0);
    check("rst_clr_n", mac_clr_n, 0);
    check("rst_in_addr", in_addr, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_mac_ab", {mac_a, mac_b}, 0);
    check("rst_out", {out_addr, out_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    fill(8'h10, 8'h10); run_pass(0);
    fill(8'h7F, 8'h7F); run_pass(0);
    fill(8'h80, 8'h7F); run_pass(0);
    fill(8'h7F, 8'h7F);
    w_mem[3] = 8'h81; w_mem[7] = 8'h81;
    run_pass(0);
    fill(8'h20, 8'h20); run_pass(0);
    fill(8'hE0, 8'h20); run_pass(0);
    fill(8'h10, 8'h10); run_pass(1);

    // Abort in the middle of ACCUM, then rerun from neuron 0.
    fill(8'h7F, 8'h7F);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_we", out_we, 0);
    check("abort_clr_n", mac_clr_n, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle", busy, 0);
    fill(8'h10, 8'h10); run_pass(0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NI; i++) in_mem[i] = 8'($urandom);
      for (int i = 0; i < NI*NO; i++)
        w_mem[i] = (r < 4) ? 8'($urandom_range(0, 31) - 16) : 8'($urandom);
      run_pass(r[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
